f_regfile_writer: RTL

//  Write-side initiator for the FP register file. Buffers FPU results (rd, data, exception flags)
//  in a small FIFO and drains them to the register-file write port, one per cycle.

---
 rtl/f_types_pkg.sv | 33 +++
 rtl/f_wb_fifo.sv | 65 ++++++
 rtl/f_regfile_writer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/f_types_pkg.sv
// Shared FP writeback types: exception flags, rounding modes, CSR selectors, FIFO entry.
package f_types_pkg;

  localparam int unsigned F_RD_W = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    DYN = 3'd7
  } frm_t;

  localparam logic [1:0] CSR_SEL_FFLAGS = 2'b01;
  localparam logic [1:0] CSR_SEL_FRM    = 2'b10;
  localparam logic [1:0] CSR_SEL_FCSR   = 2'b11;

  typedef struct packed {
    logic [F_RD_W-1:0] rd;
    logic [31:0]       data;
    fflags_t           flags;
  } f_wb_entry_t;

endpackage

// File: rtl/f_wb_fifo.sv
// Generic DEPTH-entry FIFO with synchronous flush; exposes the storage array and
// per-entry valid bits so the owner can scan pending entries.
module f_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0]             valid,
  output logic [DEPTH-1:0][WIDTH-1:0]  entries
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [DEPTH-1:0]          vld;

  // Storage is reset as well so the head presents zero after reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      mem    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata   = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign valid   = vld;
  assign entries = mem;

endmodule

// File: rtl/f_regfile_writer.sv
// FP register-file write initiator: buffers FPU results, drains one per cycle,
// owns fflags/frm CSR state and reports pending-write hazards.
module f_regfile_writer
  import f_types_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [$clog2(NUM_REGS)-1:0] res_rd,
  input  logic [31:0]                 res_data,
  input  logic [4:0]                  res_flags,
  input  logic                        f_stall,
  input  logic                        flush,
  input  logic                        csr_wen,
  input  logic [1:0]                  csr_sel,
  input  logic [7:0]                  csr_wdata,
  output logic                        f_wen,
  output logic [$clog2(NUM_REGS)-1:0] f_rd,
  output logic [31:0]                 f_w_data,
  output logic [2:0]                  f_frm_in,
  output logic [4:0]                  fflags,
  output logic [2:0]                  frm,
  input  logic [$clog2(NUM_REGS)-1:0] chk_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] chk_rs2,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  output logic                        busy
);

  localparam int unsigned RW = $clog2(NUM_REGS);
  localparam int unsigned EW = $bits(f_wb_entry_t);

  f_wb_entry_t                in_e;
  f_wb_entry_t                head_e;
  f_wb_entry_t                scan_e;
  logic [EW-1:0]              head_raw;
  logic [DEPTH-1:0][EW-1:0]   ents;
  logic [DEPTH-1:0]           vld;
  logic                       full;
  logic                       empty;
  logic                       push;
  logic                       pop;

  logic [4:0]                 fflags_q;
  logic [4:0]                 fflags_d;
  logic [2:0]                 frm_q;
  logic [2:0]                 frm_d;

  always_comb begin
    in_e       = '0;
    in_e.rd    = F_RD_W'(res_rd);
    in_e.data  = res_data;
    in_e.flags = fflags_t'(res_flags);
  end

  assign head_e    = f_wb_entry_t'(head_raw);
  assign res_ready = !full;
  assign push      = res_valid && !full && !flush;
  assign f_wen     = !empty && !f_stall && !flush;
  assign pop       = f_wen;

  f_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (in_e),
    .rdata   (head_raw),
    .full    (full),
    .empty   (empty),
    .valid   (vld),
    .entries (ents)
  );

  assign f_rd     = RW'(head_e.rd);
  assign f_w_data = head_e.data;
  assign busy     = !empty;

  // A CSR write and a drain in the same cycle merge so the drained flags survive.
  always_comb begin
    fflags_d = fflags_q;
    frm_d    = frm_q;
    if (csr_wen && (csr_sel == CSR_SEL_FFLAGS || csr_sel == CSR_SEL_FCSR))
      fflags_d = csr_wdata[4:0];
    if (pop)
      fflags_d = fflags_d | head_e.flags;
    if (csr_wen && csr_sel == CSR_SEL_FRM)
      frm_d = csr_wdata[2:0];
    else if (csr_wen && csr_sel == CSR_SEL_FCSR)
      frm_d = csr_wdata[7:5];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fflags_q <= '0;
      frm_q    <= RNE;
    end else begin
      fflags_q <= fflags_d;
      frm_q    <= frm_d;
    end
  end

  assign fflags   = fflags_q;
  assign frm      = frm_q;
  assign f_frm_in = frm_q;

  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    scan_e   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_e = f_wb_entry_t'(ents[i]);
      if (vld[i] && RW'(scan_e.rd) == chk_rs1) rs1_busy = 1'b1;
      if (vld[i] && RW'(scan_e.rd) == chk_rs2) rs2_busy = 1'b1;
    end
  end

endmodule
